// File: rtl/memory_writeback_stage.sv
// Back end of the 24-bit pipeline: EX/MEM register, word-addressed data memory,
// MEM/WB register and the writeback result mux feeding regfile, forwarding and fetch.
module memory_writeback_stage #(
  parameter int N     = 24,
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         FlushM,
  input  logic         RegWriteE,
  input  logic         MemtoRegE,
  input  logic         MemWriteE,
  input  logic         PCSrcE,
  input  logic [N-1:0] ALUResultE,
  input  logic [N-1:0] WriteDataE,
  input  logic [3:0]   WA3E,
  output logic [N-1:0] ALUResultM,
  output logic [3:0]   WA3M,
  output logic         RegWriteM,
  output logic         PCSrcM,
  output logic [N-1:0] ResultW,
  output logic [3:0]   WA3W,
  output logic         RegWriteW,
  output logic         PCSrcW
);

  localparam int AW = $clog2(DEPTH);

  logic         MemtoRegM;
  logic         MemWriteM;
  logic [N-1:0] WriteDataM;
  logic [N-1:0] ReadDataM;
  logic [AW-1:0] memIndex;

  logic         MemtoRegW;
  logic [N-1:0] ALUResultW;
  logic [N-1:0] ReadDataW;

  // NOTE: the array has no reset; it starts at zero via its declaration and
  // keeps its contents across rst, so it can map onto plain block RAM.
  logic [N-1:0] dataMem [DEPTH] = '{default: '0};

  // EX/MEM: a flush turns the entering instruction into an all-zero bubble.
  // NOTE: every clocked assignment uses <= so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || FlushM) begin
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      PCSrcM     <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE;
      PCSrcM     <= PCSrcE;
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      WA3M       <= WA3E;
    end
  end

  // Upper address bits are dropped, so addresses wrap modulo DEPTH.
  assign memIndex  = ALUResultM[AW-1:0];
  assign ReadDataM = dataMem[memIndex];

  always_ff @(posedge clk) begin
    if (MemWriteM && !rst) begin
      dataMem[memIndex] <= WriteDataM;
    end
  end

  // MEM/WB advances every cycle; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW  <= 1'b0;
      PCSrcW     <= 1'b0;
      MemtoRegW  <= 1'b0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      WA3W       <= '0;
    end else begin
      RegWriteW  <= RegWriteM;
      PCSrcW     <= PCSrcM;
      MemtoRegW  <= MemtoRegM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= ReadDataM;
      WA3W       <= WA3M;
    end
  end

  assign ResultW = MemtoRegW ? ReadDataW : ALUResultW;

endmodule
